// File: rtl/vita_capture_pkg.sv
// Shared types for the VITA ROI capture block: FSM state encoding and the
// sync-flag priority decode used when several flags arrive in the same cycle.
package vita_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLine,
        StWaitId,
        StWaitLs,
        StEndOfF
    } state_e;

    // Bit positions in the packed data-flag vector; higher index wins.
    localparam int unsigned NumFlags = 5;
    localparam int unsigned FlagImg  = 0;
    localparam int unsigned FlagLe   = 1;
    localparam int unsigned FlagLs   = 2;
    localparam int unsigned FlagFe   = 3;
    localparam int unsigned FlagFs   = 4;

    typedef enum logic [2:0] {
        FlgNone,
        FlgImg,
        FlgLe,
        FlgLs,
        FlgFe,
        FlgFs
    } flag_e;

    // Reduce the raw flag vector to the single highest-priority flag.
    function automatic flag_e decode_flags(input logic [NumFlags-1:0] flags);
        flag_e f;
        f = FlgNone;
        if (flags[FlagFs]) begin
            f = FlgFs;
        end else if (flags[FlagFe]) begin
            f = FlgFe;
        end else if (flags[FlagLs]) begin
            f = FlgLs;
        end else if (flags[FlagLe]) begin
            f = FlgLe;
        end else if (flags[FlagImg]) begin
            f = FlgImg;
        end
        return f;
    endfunction

endpackage

// File: rtl/vita_roi_window.sv
// ROI window: holds the frame-start copy of the ROI bounds and decides whether
// the current kernel/line position lies inside the inclusive window.
module vita_roi_window #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 11
) (
    input  logic          pclock_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [XW-1:0] x_start_i,
    input  logic [XW-1:0] x_end_i,
    input  logic [YW-1:0] y_start_i,
    input  logic [YW-1:0] y_end_i,
    input  logic [XW-1:0] kernel_idx_i,
    input  logic [YW-1:0] line_idx_i,
    output logic          in_roi_o
);
    import vita_capture_pkg::*;

    logic [XW-1:0] x_start_q, x_end_q;
    logic [YW-1:0] y_start_q, y_end_q;
    logic [XW-1:0] x_lo, x_hi;
    logic [YW-1:0] y_lo, y_hi;

    // Shadow the bounds only at frame start so mid-frame edits wait a frame.
    always_ff @(posedge pclock_i or posedge reset_i) begin
        if (reset_i) begin
            x_start_q <= '0;
            x_end_q   <= '0;
            y_start_q <= '0;
            y_end_q   <= '0;
        end else if (load_i) begin
            x_start_q <= x_start_i;
            x_end_q   <= x_end_i;
            y_start_q <= y_start_i;
            y_end_q   <= y_end_i;
        end
    end

    // The frame-start cycle is itself kernel 0 of line 0, so it must be
    // judged against the bounds being loaded rather than the stale shadow.
    always_comb begin
        x_lo     = load_i ? x_start_i : x_start_q;
        x_hi     = load_i ? x_end_i   : x_end_q;
        y_lo     = load_i ? y_start_i : y_start_q;
        y_hi     = load_i ? y_end_i   : y_end_q;
        in_roi_o = (x_lo <= kernel_idx_i) && (kernel_idx_i <= x_hi) &&
                   (y_lo <= line_idx_i)   && (line_idx_i   <= y_hi);
    end

endmodule

// File: rtl/vita_roi_capture.sv
// VITA sync-decoded ROI capture: tracks frame/line/kernel position from the
// decoded sync flags, forwards in-window kernels one cycle later, and reports
// line/frame events and protocol errors.
module vita_roi_capture #(
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = 10,
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 11
) (
    input  logic              pclock,
    input  logic              reset,
    input  logic              enable,
    input  logic              FS,
    input  logic              FE,
    input  logic              LS,
    input  logic              LE,
    input  logic              IMG,
    input  logic              ID,
    input  logic              LL,
    input  logic [NCH*PW-1:0] din,
    input  logic [XW-1:0]     x_start,
    input  logic [XW-1:0]     x_end,
    input  logic [YW-1:0]     y_start,
    input  logic [YW-1:0]     y_end,
    output logic [NCH*PW-1:0] dout,
    output logic              dout_valid,
    output logic              end_line,
    output logic              end_frame,
    output logic [YW-1:0]     line_idx,
    output logic [15:0]       frame_cnt,
    output logic              err_sync
);
    import vita_capture_pkg::*;

    state_e              state_q;
    logic [XW-1:0]       kernel_idx_q;
    logic [YW-1:0]       line_idx_q;
    logic [15:0]         frame_cnt_q;
    logic                last_line_q;
    logic [NCH*PW-1:0]   dout_q;
    logic                dout_valid_q;
    logic                end_line_q;
    logic                end_frame_q;
    logic                err_sync_q;

    logic [NumFlags-1:0] flags;
    flag_e               flag;
    logic                is_data;
    logic                fs_restart;
    logic                line_start;
    logic                capture;
    logic                in_roi;
    logic [XW-1:0]       k_cur;
    logic [XW-1:0]       k_next;
    logic [YW-1:0]       y_cur;
    logic [YW-1:0]       line_inc;

    // Decode the cycle: which flag wins, whether it starts a line, and the
    // kernel/line position this cycle's data belongs to.
    always_comb begin
        flags          = '0;
        flags[FlagFs]  = FS;
        flags[FlagFe]  = FE;
        flags[FlagLs]  = LS;
        flags[FlagLe]  = LE;
        flags[FlagImg] = IMG;
        flag           = decode_flags(flags);
        is_data        = (flag != FlgNone);
        // enable only gates leaving IDLE; a mid-frame FS always restarts.
        fs_restart     = (flag == FlgFs) && ((state_q != StIdle) || enable);
        line_start     = fs_restart ||
                         ((flag == FlgLs) && ((state_q == StLine) || (state_q == StWaitLs)));
        capture        = line_start || ((state_q == StLine) && is_data);
        k_cur          = line_start ? '0 : kernel_idx_q;
        k_next         = (k_cur == '1) ? k_cur : k_cur + XW'(1);
        y_cur          = fs_restart ? '0 : line_idx_q;
        line_inc       = (line_idx_q == '1) ? line_idx_q : line_idx_q + YW'(1);
    end

    vita_roi_window #(
        .XW (XW),
        .YW (YW)
    ) u_window (
        .pclock_i     (pclock),
        .reset_i      (reset),
        .load_i       (fs_restart),
        .x_start_i    (x_start),
        .x_end_i      (x_end),
        .y_start_i    (y_start),
        .y_end_i      (y_end),
        .kernel_idx_i (k_cur),
        .line_idx_i   (y_cur),
        .in_roi_o     (in_roi)
    );

    // Frame/line FSM with counters and all registered outputs.
    always_ff @(posedge pclock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            kernel_idx_q <= '0;
            line_idx_q   <= '0;
            frame_cnt_q  <= '0;
            last_line_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            end_line_q   <= 1'b0;
            end_frame_q  <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            end_line_q   <= 1'b0;
            end_frame_q  <= 1'b0;
            err_sync_q   <= 1'b0;
            dout_valid_q <= 1'b0;

            if (capture) begin
                kernel_idx_q <= k_next;
            end
            if (capture && in_roi) begin
                dout_q       <= din;
                dout_valid_q <= 1'b1;
            end

            if (fs_restart) begin
                // A partial frame is dropped silently apart from err_sync.
                state_q     <= StLine;
                line_idx_q  <= '0;
                last_line_q <= 1'b0;
                err_sync_q  <= (state_q != StIdle);
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Non-FS traffic between frames is not an error.
                    end
                    StLine: begin
                        case (flag)
                            FlgFe: begin
                                state_q     <= StWaitId;
                                last_line_q <= 1'b1;
                            end
                            FlgLe:   state_q    <= StWaitId;
                            FlgLs:   err_sync_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    StWaitId: begin
                        if (ID) begin
                            end_line_q  <= 1'b1;
                            line_idx_q  <= line_inc;
                            last_line_q <= 1'b0;
                            if (LL || last_line_q) begin
                                state_q     <= StEndOfF;
                                end_frame_q <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                            end else begin
                                state_q <= StWaitLs;
                            end
                        end else if (is_data) begin
                            // Any line data before the ID word is out of order.
                            err_sync_q <= 1'b1;
                        end
                    end
                    StWaitLs: begin
                        if (flag == FlgLs) begin
                            state_q <= StLine;
                        end else if (is_data) begin
                            err_sync_q <= 1'b1;
                        end
                    end
                    StEndOfF: state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign end_line   = end_line_q;
    assign end_frame  = end_frame_q;
    assign line_idx   = line_idx_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_vita_roi_capture.sv
// Bench for vita_roi_capture: table of whole-frame vectors plus hand-written
// error/reset/enable sequences; ROI data checked through an expected queue.
module tb_vita_roi_capture;

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 10;
    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 11;
    localparam int unsigned DW  = NCH * PW;

    localparam int KNone = 0;
    localparam int KFs   = 1;
    localparam int KFe   = 2;
    localparam int KLs   = 3;
    localparam int KLe   = 4;
    localparam int KImg  = 5;

    logic          pclock = 1'b0;
    logic          reset;
    logic          enable;
    logic          FS, FE, LS, LE, IMG, ID, LL;
    logic [DW-1:0] din;
    logic [XW-1:0] x_start, x_end;
    logic [YW-1:0] y_start, y_end;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          end_line;
    logic          end_frame;
    logic [YW-1:0] line_idx;
    logic [15:0]   frame_cnt;
    logic          err_sync;

    vita_roi_capture #(
        .NCH (NCH),
        .PW  (PW),
        .XW  (XW),
        .YW  (YW)
    ) dut (
        .pclock     (pclock),
        .reset      (reset),
        .enable     (enable),
        .FS         (FS),
        .FE         (FE),
        .LS         (LS),
        .LE         (LE),
        .IMG        (IMG),
        .ID         (ID),
        .LL         (LL),
        .din        (din),
        .x_start    (x_start),
        .x_end      (x_end),
        .y_start    (y_start),
        .y_end      (y_end),
        .dout       (dout),
        .dout_valid (dout_valid),
        .end_line   (end_line),
        .end_frame  (end_frame),
        .line_idx   (line_idx),
        .frame_cnt  (frame_cnt),
        .err_sync   (err_sync)
    );

    always #5 pclock = ~pclock;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_val = 0;
    int            n_el  = 0;
    int            n_ef  = 0;
    int            n_err = 0;
    int            exp_fc = 0;
    int            m_xs, m_xe, m_ys, m_ye;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_dout = '0;

    typedef struct {
        int xs, xe, ys, ye, nl, nk;
        bit fe;
        int e_val, e_el, e_ef;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic set_flags(input int kind);
        FS  = (kind == KFs);
        FE  = (kind == KFe);
        LS  = (kind == KLs);
        LE  = (kind == KLe);
        IMG = (kind == KImg);
    endtask

    task automatic idle_cyc();
        @(posedge pclock);
        #1;
    endtask

    // One data cycle at (line l, kernel k); queue the data if the model says
    // it is captured and inside the bounds latched at the last accepted FS.
    task automatic data_cyc(input int kind, input int l, input int k, input bit cap);
        logic [63:0] r;
        r   = {$urandom, $urandom};
        din = r[DW-1:0];
        set_flags(kind);
        if (cap && k >= m_xs && k <= m_xe && l >= m_ys && l <= m_ye) exp_q.push_back(din);
        @(posedge pclock);
        #1;
        set_flags(KNone);
    endtask

    task automatic fs_cyc(input bit accept);
        if (accept) begin
            m_xs = int'(x_start);
            m_xe = int'(x_end);
            m_ys = int'(y_start);
            m_ye = int'(y_end);
        end
        data_cyc(KFs, 0, 0, accept);
    endtask

    task automatic line_cyc(input int l, input int kfrom, input int kto, input int nk,
                            input bit first, input bit last_fe);
        int kind;
        for (int k = kfrom; k <= kto; k++) begin
            if (k == 0 && first) begin
                fs_cyc(1'b1);
            end else begin
                kind = (k == 0) ? KLs : (k == nk - 1) ? (last_fe ? KFe : KLe) : KImg;
                data_cyc(kind, l, k, 1'b1);
            end
        end
    endtask

    task automatic line_end(input bit ll);
        idle_cyc();
        ID = 1'b1;
        LL = ll;
        idle_cyc();
        ID = 1'b0;
        LL = 1'b0;
        idle_cyc();
    endtask

    task automatic run_line(input int l, input int nk, input bit first, input bit last_fe,
                            input bit ll);
        line_cyc(l, 0, nk - 1, nk, first, last_fe);
        line_end(ll);
    endtask

    task automatic run_frame(input int nl, input int nk, input bit fe);
        for (int l = 0; l < nl; l++) begin
            run_line(l, nk, l == 0, fe && (l == nl - 1), !fe && (l == nl - 1));
        end
        idle_cyc();
        idle_cyc();
        exp_fc++;
    endtask

    task automatic clr_cnt();
        n_val = 0;
        n_el  = 0;
        n_ef  = 0;
        n_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_dout"}, longint'(dout), 0);
        check({tag, "_dout_valid"}, longint'(dout_valid), 0);
        check({tag, "_end_line"}, longint'(end_line), 0);
        check({tag, "_end_frame"}, longint'(end_frame), 0);
        check({tag, "_err_sync"}, longint'(err_sync), 0);
        check({tag, "_line_idx"}, longint'(line_idx), 0);
        check({tag, "_frame_cnt"}, longint'(frame_cnt), 0);
    endtask

    task automatic chk_frame(input string tag, input int e_val, input int e_el, input int e_ef,
                             input int e_err);
        check({tag, "_valid_count"}, n_val, e_val);
        check({tag, "_end_line_count"}, n_el, e_el);
        check({tag, "_end_frame_count"}, n_ef, e_ef);
        check({tag, "_err_count"}, n_err, e_err);
        check({tag, "_frame_cnt"}, longint'(frame_cnt), exp_fc);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    // Output monitor: pops expected ROI data, checks hold and pulse pairing.
    initial begin : monitor
        forever begin
            @(negedge pclock);
            if (reset) begin
                last_dout = '0;
            end else begin
                if (dout_valid) begin
                    n_val++;
                    if (exp_q.size() == 0) begin
                        check("dout_valid_unexpected", longint'(dout_valid), 0);
                    end else begin
                        check("dout_data", longint'(dout), longint'(exp_q.pop_front()));
                    end
                    last_dout = dout;
                end else begin
                    check("dout_hold", longint'(dout), longint'(last_dout));
                end
                if (end_line) n_el++;
                if (end_frame) begin
                    n_ef++;
                    check("end_frame_with_end_line", longint'(end_line), 1);
                end
                if (err_sync) n_err++;
            end
        end
    end

    initial begin : stim
        vt[0] = '{2, 5, 1, 2, 4, 8, 1'b0, 8, 4, 1};
        vt[1] = '{0, 7, 0, 3, 4, 8, 1'b0, 32, 4, 1};
        vt[2] = '{5, 2, 1, 2, 4, 8, 1'b0, 0, 4, 1};
        vt[3] = '{2, 5, 2, 1, 4, 8, 1'b0, 0, 4, 1};
        vt[4] = '{7, 7, 3, 3, 4, 8, 1'b1, 1, 4, 1};
        vt[5] = '{0, 0, 0, 0, 2, 3, 1'b0, 1, 2, 1};
        vt[6] = '{0, 7, 5, 9, 3, 8, 1'b1, 0, 3, 1};

        reset   = 1'b1;
        enable  = 1'b1;
        set_flags(KNone);
        ID      = 1'b0;
        LL      = 1'b0;
        din     = '0;
        x_start = XW'(2);
        x_end   = XW'(5);
        y_start = YW'(1);
        y_end   = YW'(2);
        m_xs = 0; m_xe = 0; m_ys = 0; m_ye = 0;
        idle_cyc();
        idle_cyc();
        chk_zero("reset");
        reset = 1'b0;
        idle_cyc();

        // Whole-frame vectors.
        for (int i = 0; i < 7; i++) begin
            x_start = XW'(vt[i].xs);
            x_end   = XW'(vt[i].xe);
            y_start = YW'(vt[i].ys);
            y_end   = YW'(vt[i].ye);
            clr_cnt();
            run_frame(vt[i].nl, vt[i].nk, vt[i].fe);
            chk_frame($sformatf("vec%0d", i), vt[i].e_val, vt[i].e_el, vt[i].e_ef, 0);
            check($sformatf("vec%0d_line_idx", i), longint'(line_idx), vt[i].nl);
        end

        // Bounds edited mid-frame take effect at the following FS.
        x_start = XW'(2); x_end = XW'(5); y_start = YW'(1); y_end = YW'(2);
        clr_cnt();
        run_line(0, 8, 1'b1, 1'b0, 1'b0);
        line_cyc(1, 0, 3, 8, 1'b0, 1'b0);
        x_end = XW'(7);
        line_cyc(1, 4, 7, 8, 1'b0, 1'b0);
        line_end(1'b0);
        run_line(2, 8, 1'b0, 1'b0, 1'b0);
        run_line(3, 8, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        idle_cyc();
        exp_fc++;
        chk_frame("shadow_old", 8, 4, 1, 0);
        clr_cnt();
        run_frame(4, 8, 1'b0);
        chk_frame("shadow_new", 12, 4, 1, 0);
        x_end = XW'(5);

        // FS at line 2 kernel 3 restarts the frame.
        clr_cnt();
        run_line(0, 8, 1'b1, 1'b0, 1'b0);
        run_line(1, 8, 1'b0, 1'b0, 1'b0);
        line_cyc(2, 0, 2, 8, 1'b0, 1'b0);
        fs_cyc(1'b1);
        check("fs_restart_err_sync", longint'(err_sync), 1);
        check("fs_restart_line_idx", longint'(line_idx), 0);
        check("fs_restart_frame_cnt", longint'(frame_cnt), exp_fc);
        line_cyc(0, 1, 7, 8, 1'b0, 1'b0);
        line_end(1'b0);
        run_line(1, 8, 1'b0, 1'b0, 1'b0);
        run_line(2, 8, 1'b0, 1'b0, 1'b0);
        run_line(3, 8, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        idle_cyc();
        exp_fc++;
        chk_frame("fs_restart", 13, 6, 1, 1);

        // LS inside a line restarts the kernel count; LE in WAIT_LS is ignored.
        clr_cnt();
        run_line(0, 8, 1'b1, 1'b0, 1'b0);
        line_cyc(1, 0, 3, 8, 1'b0, 1'b0);
        data_cyc(KLs, 1, 0, 1'b1);
        check("ls_in_line_err_sync", longint'(err_sync), 1);
        line_cyc(1, 1, 7, 8, 1'b0, 1'b0);
        line_end(1'b0);
        data_cyc(KLe, 2, 0, 1'b0);
        check("le_in_wait_ls_err_sync", longint'(err_sync), 1);
        check("le_in_wait_ls_line_idx", longint'(line_idx), 2);
        idle_cyc();
        run_line(2, 8, 1'b0, 1'b0, 1'b0);
        run_line(3, 8, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        idle_cyc();
        exp_fc++;
        chk_frame("ls_le_errors", 10, 4, 1, 2);

        // Asynchronous reset in the middle of line 1.
        clr_cnt();
        run_line(0, 8, 1'b1, 1'b0, 1'b0);
        line_cyc(1, 0, 3, 8, 1'b0, 1'b0);
        #5;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        idle_cyc();
        idle_cyc();
        reset = 1'b0;
        exp_q.delete();
        exp_fc = 0;
        check("mid_reset_end_frame_count", n_ef, 0);
        idle_cyc();
        clr_cnt();
        run_frame(4, 8, 1'b0);
        chk_frame("after_reset", 8, 4, 1, 0);

        // enable=0 mid-frame: the frame completes, the next FS is ignored.
        clr_cnt();
        run_line(0, 8, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        run_line(1, 8, 1'b0, 1'b0, 1'b0);
        run_line(2, 8, 1'b0, 1'b0, 1'b0);
        run_line(3, 8, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        idle_cyc();
        exp_fc++;
        chk_frame("disable_finish", 8, 4, 1, 0);
        clr_cnt();
        fs_cyc(1'b0);
        for (int k = 1; k < 7; k++) data_cyc(KImg, 0, k, 1'b0);
        data_cyc(KLe, 0, 7, 1'b0);
        line_end(1'b1);
        idle_cyc();
        chk_frame("disable_ignored", 0, 0, 0, 0);
        check("disable_ignored_line_idx", longint'(line_idx), 4);
        enable = 1'b1;
        idle_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
